// File: rtl/imem_loader.sv
// Packs a valid/ready byte stream into big-endian 32-bit instruction-memory word writes.
// Optional trailing checksum byte check when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LEN_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDRESS_WIDTH-1:0]  base_addr_i,
  input  logic [LEN_WIDTH-1:0]      len_i,
  input  logic                      s_valid_i,
  input  logic [DATA_WIDTH-1:0]     s_data_i,
  output logic                      s_ready_o,
  output logic                      we_o,
  output logic [ADDRESS_WIDTH-1:0]  waddr_o,
  output logic [4*DATA_WIDTH-1:0]   wdata_o,
  output logic [3:0]                wbe_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCollect = 3'd1;
  localparam logic [2:0] StWrite   = 3'd2;
  localparam logic [2:0] StDone    = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] StCheck   = 3'd3;
  localparam logic [2:0] StAfter   = StCheck;
`else
  localparam logic [2:0] StAfter   = StDone;
`endif

  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
  logic [4*DATA_WIDTH-1:0]  word_q, word_d;
  logic [3:0]               wbe_q, wbe_d;
  logic [1:0]               idx_q, idx_d;
  logic [1:0]               lane;
  logic                     hs;

  // First byte of a word lands in the most significant lane.
  assign lane = 2'd3 - idx_q;
  assign hs   = s_valid_i & s_ready_o;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] ck_total;
  logic       err_q, err_d;

  assign ck_total = sum_q + s_data_i[7:0];
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wbe_d   = wbe_q;
    idx_d   = idx_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d = base_addr_i & ~ADDRESS_WIDTH'(3);
          cnt_d  = len_i;
          word_d = '0;
          wbe_d  = '0;
          idx_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = '0;
          err_d  = 1'b0;
`endif
          state_d = (len_i == '0) ? StAfter : StCollect;
        end
      end
      StCollect: begin
        if (hs) begin
          word_d[lane*DATA_WIDTH +: DATA_WIDTH] = s_data_i;
          wbe_d[lane] = 1'b1;
          idx_d       = idx_q + 2'd1;
          cnt_d       = cnt_q - LEN_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_q + s_data_i[7:0];
`endif
          if ((idx_q == 2'd3) || (cnt_q == LEN_WIDTH'(1))) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + ADDRESS_WIDTH'(4);
        word_d  = '0;
        wbe_d   = '0;
        idx_d   = '0;
        state_d = (cnt_q != '0) ? StCollect : StAfter;
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (hs) begin
          err_d   = (ck_total != 8'h00);
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      wbe_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wbe_q   <= wbe_d;
      idx_q   <= idx_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err_o     = err_q;
  assign s_ready_o = (state_q == StCollect) || (state_q == StCheck);
`else
  assign err_o     = 1'b0;
  assign s_ready_o = (state_q == StCollect);
`endif

  assign we_o    = (state_q == StWrite);
  assign waddr_o = addr_q;
  assign wdata_o = word_q;
  assign wbe_o   = wbe_q;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-list reference model.
module tb_imem_loader;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

`ifdef LOADER_CHECKSUM_EN
  localparam int CkExtra = 1;
`else
  localparam int CkExtra = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, we, busy, done, err;
  logic [31:0] waddr, wdata;
  logic [3:0]  wbe;

  int checks = 0;
  int failures = 0;
  int cyc = 0, start_cyc = 0, we_cyc = 0, done_cyc = 0;
  int done_n = 0, sr_viol = 0;
  wr_t obs[$];
  logic [7:0] pay[$];
  logic [7:0] ck_byte;

  imem_loader dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_i       (len),
    .s_valid_i   (s_valid),
    .s_data_i    (s_data),
    .s_ready_o   (s_ready),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .wbe_o       (wbe),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (start) start_cyc = cyc;
    #2;
    if (we) begin
      obs.push_back('{a: waddr, d: wdata, be: wbe});
      we_cyc = cyc;
      if (s_ready) sr_viol++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_s_ready"}, 32'(s_ready), 0);
    check({pfx, "_we"},      32'(we), 0);
    check({pfx, "_waddr"},   waddr, 0);
    check({pfx, "_wdata"},   wdata, 0);
    check({pfx, "_wbe"},     32'(wbe), 0);
    check({pfx, "_busy"},    32'(busy), 0);
    check({pfx, "_done"},    32'(done), 0);
    check({pfx, "_err"},     32'(err), 0);
  endtask

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  // Loads pay[0..n-1] at base and compares every write against the model.
  task automatic do_load(input logic [31:0] base, input int n, input int gap, input bit glitch);
    wr_t exp_q[$];
    wr_t e;
    int idx, guard, nw;
    bit hs;
    logic [7:0] sum;
    logic [31:0] wbase;
    logic exp_err;

    nw = (n + 3) / 4;
    wbase = {base[31:2], 2'b00};
    sum = '0;
    for (int w = 0; w < nw; w++) begin
      e.a = wbase + 32'(4 * w);
      e.d = '0;
      e.be = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * w + l < n) begin
          e.d[31 - 8*l -: 8] = pay[4*w + l];
          e.be[3 - l] = 1'b1;
          sum = sum + pay[4*w + l];
        end
      end
      exp_q.push_back(e);
    end
    sum = sum + ck_byte;
    exp_err = (CkExtra == 1) && (sum != 8'h00);

    obs.delete();
    done_n = 0;
    sr_viol = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; len = 16'(n);
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; len = 16'($urandom);
    check("busy_rise", 32'(busy), 1);

    idx = 0; guard = 0;
    while (idx < n && guard < 4000) begin
      s_valid = ($urandom_range(0, 99) >= gap);
      s_data = pay[idx];
      if (glitch && idx == 1) begin
        start = 1'b1; base_addr = $urandom; len = 16'($urandom_range(1, 50));
      end
      hs = s_valid && s_ready;
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (hs) idx++;
    end
    check("bytes_taken", 32'(idx), 32'(n));
`ifdef LOADER_CHECKSUM_EN
    hs = 1'b0; guard = 0;
    while (!hs && guard < 100) begin
      s_valid = 1'b1; s_data = ck_byte;
      hs = s_ready;
      @(negedge clk);
      guard++;
    end
`endif
    s_valid = 1'b0;

    guard = 0;
    while (done_n == 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);

    check("done_pulses", 32'(done_n), 1);
    check("busy_end", 32'(busy), 0);
    check("done_end", 32'(done), 0);
    check("err", 32'(err), 32'(exp_err));
    check("sready_in_write", 32'(sr_viol), 0);
    if (n > 0) check("done_after_write", 32'(done_cyc - we_cyc), 32'(1 + CkExtra));
    else       check("done_after_start", 32'(done_cyc - start_cyc), 32'(CkExtra));
    check("nwrites", 32'(obs.size()), 32'(nw));
    for (int i = 0; i < nw && i < obs.size(); i++) begin
      check($sformatf("waddr[%0d]", i), obs[i].a, exp_q[i].a);
      check($sformatf("wdata[%0d]", i), obs[i].d, exp_q[i].d);
      check($sformatf("wbe[%0d]", i), 32'(obs[i].be), 32'(exp_q[i].be));
    end
  endtask

  initial begin
    ck_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a word: nothing may be written.
    obs.delete();
    start = 1'b1; base_addr = 32'h0; len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'h11;
    @(negedge clk);
    s_data = 8'h22;
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_no_write", 32'(obs.size()), 0);

    fill_random(4);
    ck_byte = 8'($urandom);
    do_load(32'h0, 4, 0, 1'b0);

    pay = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h85, 8'h15, 8'h00};
    do_load(32'h10, 8, 0, 1'b0);

    fill_random(4);
    pay.push_back(8'hAA);
    pay.push_back(8'hBB);
    do_load(32'h7, 6, 0, 1'b0);

    pay.delete();
    do_load(32'h40, 0, 0, 1'b0);

    fill_random(10);
    do_load(32'h100, 10, 50, 1'b1);

    fill_random(8);
    do_load(32'hFFFF_FFFC, 8, 20, 1'b0);

    pay = '{8'h01, 8'h02};
    ck_byte = 8'hFD;
    do_load(32'h200, 2, 0, 1'b0);
    ck_byte = 8'hFC;
    do_load(32'h200, 2, 30, 1'b0);

    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_random(n);
      ck_byte = 8'($urandom);
      do_load($urandom, n, $urandom_range(0, 60), t[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the byte-addressed instruction memory. It accepts a stream of program bytes over a valid/ready handshake and packs them into 32-bit words. It issues word writes with byte enables so that a later fetch of four consecutive bytes at address a returns {mem[a], mem[a+1], mem[a+2], mem[a+3]}. It sits between the host/UART byte source and the write port of the instruction RAM, and is idle once the program is loaded.

## Interface
- ADDRESS_WIDTH, 32, width of byte addresses
- DATA_WIDTH, 8, width of one memory location and of the input stream
- LEN_WIDTH, 16, width of the payload byte count
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  load request; sampled only in IDLE
- base_addr  in  ADDRESS_WIDTH  first byte address; bits [1:0] ignored (treated as 0)
- len  in  LEN_WIDTH  number of payload bytes
- s_valid  in  1  stream byte valid
- s_data  in  DATA_WIDTH  stream byte
- s_ready  out  1  loader can accept a byte
- we  out  1  word write strobe, one cycle per word
- waddr  out  ADDRESS_WIDTH  word-aligned byte address of the write
- wdata  out  4*DATA_WIDTH  packed word; first byte of the word in [31:24]
- wbe  out  4  byte enables; wbe[3] is the lane of waddr+0, wbe[0] is the lane of waddr+3
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  checksum mismatch flag; see Configuration

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (macro only), DONE.
- IDLE, start=1:
  - Latch base_addr&~3 into the address register and len into the remaining-byte counter.
  - Clear the word buffer, lane index, running sum and err.
  - Next state COLLECT. If len=0, next state DONE, or CHECK with the macro.
- start while not IDLE is ignored.
- COLLECT:
  - s_ready=1.
  - Each handshake (s_valid&&s_ready) stores s_data into lane 3-idx, sets wbe bit 3-idx, increments idx and decrements the counter.
  - Go to WRITE when idx reaches 4 or the counter reaches 0.
- WRITE:
  - s_ready=0, we=1; waddr, wdata and wbe come from the registers.
  - On exit: address += 4, modulo 2^ADDRESS_WIDTH; buffer, wbe and idx cleared.
  - Next state COLLECT if the counter is nonzero, else DONE (or CHECK with the macro).
- Partial final word: only the lanes received are enabled. Unused lanes of wdata are 0.
- DONE: done=1 for one cycle, then IDLE.
- Reset, including mid-load: state returns to IDLE, the partial word is discarded and no write is issued.

## Timing
- Reset values: s_ready=0, we=0, waddr=0, wdata=0, wbe=0, busy=0, done=0, err=0.
- All outputs are registered or decoded from state only. s_ready does not depend on s_valid.
- busy rises the cycle after start is accepted.
- we asserts the cycle after the 4th byte (or the last byte) of a word is accepted. The write lasts exactly one cycle.
- Sustained throughput: 4 bytes per 5 cycles.
- done pulses the cycle after the final WRITE (or CHECK) completes. busy falls in the same cycle as that done pulse ends.
- Stream stalls (s_valid=0) hold all state indefinitely. There is no timeout.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum is kept over the payload bytes.
  - After the payload, the CHECK state accepts exactly one extra byte (s_ready=1).
  - err is set if (sum + checksum byte) mod 256 != 0, and is valid with done. It holds until the next accepted start or reset.
  - The checksum byte is never written to memory.
- LOADER_CHECKSUM_EN not defined: no CHECK state, no sum register, err tied to 0.

## Test plan
- Reset check: assert rst mid-word after 2 of 4 bytes are accepted -> no we pulse; all outputs 0; next start with base 0x0, len 4 loads normally.
- Full words: base 0x10, len 8, bytes 0x13,0x05,0x00,0x00,0x93,0x85,0x15,0x00 ->
  - we at 0x10 with wdata 0x13050000, wbe 0xF
  - we at 0x14 with wdata 0x93851500, wbe 0xF
  - done 1 cycle after the 2nd write
- Partial tail and alignment: base 0x7 (treated as 0x4), len 6 ->
  - first write at 0x4 with wbe 0xF
  - second write at 0x8 with wdata 0xAABB0000, wbe 0xC for tail bytes 0xAA,0xBB
- Corner cases:
  - len=0 -> no we; done 1 cycle after start (2 with the macro, after the checksum byte)
  - start asserted while busy -> ignored, counters unchanged
  - base 0xFFFFFFFC, len 8 -> second write wraps to waddr 0x0
- Backpressure and stalls: random s_valid gaps -> byte order and addresses unchanged; s_ready=0 during every WRITE cycle; no byte lost or duplicated.
- LOADER_CHECKSUM_EN:
  - payload 0x01,0x02 with checksum 0xFD -> err=0
  - same payload with checksum 0xFC -> err=1 with done; memory writes identical in both cases.
